alufu_q: RTL and testbench

Parametrised integer ALU functional unit with independent result queues toward the common data bus (CDB) and the reorder buffer (ROB). It sits behind the reservation-station issue port and replaces the single-entry skid register of the first-generation ALU unit with a DEPTH-entry FIFO per channel. It also extends the opcode set with shifts, compares and pass-through operations. Both output channels use the existing daisy-chained, wired-OR arbitration: an upstream claim always wins, and an unclaimed bus drives zeros.

---
 rtl/alufu_q.sv | 171 +++++++++++++++++
 tb/tb_alufu_q.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alufu_q.sv
// Integer ALU functional unit with independent DEPTH-entry result queues toward
// the CDB and the ROB, each behind a daisy-chained wired-OR bus claim.
module alufu_q #(
  parameter int W     = 8,
  parameter int TAGW  = 4,
  parameter int WBSW  = 8,
  parameter int FLAGW = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                input_transmit,
  input  logic [7:0]          operand,
  input  logic [1:0][W-1:0]   depvals,
  input  logic [WBSW-1:0]     wbs,
  input  logic [FLAGW-1:0]    flags,
  input  logic [TAGW-1:0]     robid,
  input  logic                cdb_transmit,
  output logic                cdb_transmit_out,
  output logic [TAGW-1:0]     cdb_id,
  output logic [W-1:0]        cdb_val,
  input  logic                rob_transmit,
  output logic                rob_transmit_out,
  output logic [TAGW-1:0]     robid_out,
  output logic [FLAGW-1:0]    flags_out,
  output logic [WBSW-1:0]     wbs_out,
  output logic [W-1:0]        value_out,
  output logic                busy,
  output logic                overflow
);

  localparam int SHW = $clog2(W);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);

  logic [W-1:0]     a, b, result;
  logic [SHW-1:0]   sh;
  logic             big_shift;
  logic             unused_operand;

  assign a              = depvals[1];
  assign b              = depvals[0];
  assign sh             = b[SHW-1:0];
  assign big_shift      = |b[W-1:SHW];
  assign unused_operand = ^operand[3:0];

  always_comb begin
    result = '0;
    case (operand[7:4])
      4'h0: result = a + b;
      4'h1: result = a - b;
      4'h2: result = a & b;
      4'h3: result = a | b;
      4'h4: result = a ^ b;
      4'h5: result = ~(a | b);
      4'h6: result = ~(a & b);
      4'h7: result = ~(a ^ b);
      4'h8: result = big_shift ? '0 : a << sh;
      4'h9: result = big_shift ? '0 : a >> sh;
      4'hA: result = big_shift ? {W{a[W-1]}} : W'($signed(a) >>> sh);
      4'hB: result = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      4'hC: result = {{(W-1){1'b0}}, a < b};
      4'hD: result = a;
      4'hE: result = b;
      default: result = '0;
    endcase
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [CW-1:0] cdb_cnt, rob_cnt;
  logic [PW-1:0] cdb_head, cdb_tail, rob_head, rob_tail;

  logic [W-1:0]     cdb_res_q [DEPTH];
  logic [TAGW-1:0]  cdb_tag_q [DEPTH];
  logic [W-1:0]     rob_res_q [DEPTH];
  logic [WBSW-1:0]  rob_wbs_q [DEPTH];
  logic [FLAGW-1:0] rob_flg_q [DEPTH];
  logic [TAGW-1:0]  rob_id_q  [DEPTH];

  logic issue_ok;
  logic cdb_empty, rob_empty, cdb_grant, rob_grant;
  logic cdb_push, cdb_pop, rob_push, rob_pop;

  // A dropped issue must not claim either bus or bypass onto it.
  assign busy      = (cdb_cnt == CW'(DEPTH)) | (rob_cnt == CW'(DEPTH));
  assign issue_ok  = input_transmit & ~busy;
  assign cdb_empty = (cdb_cnt == '0);
  assign rob_empty = (rob_cnt == '0);

  assign cdb_grant = (issue_ok | ~cdb_empty) & ~cdb_transmit;
  assign rob_grant = (issue_ok | ~rob_empty) & ~rob_transmit;

  assign cdb_transmit_out = cdb_transmit | issue_ok | ~cdb_empty;
  assign rob_transmit_out = rob_transmit | issue_ok | ~rob_empty;

  assign cdb_push = issue_ok & ~(cdb_empty & cdb_grant);
  assign cdb_pop  = cdb_grant & ~cdb_empty;
  assign rob_push = issue_ok & ~(rob_empty & rob_grant);
  assign rob_pop  = rob_grant & ~rob_empty;

  always_comb begin
    cdb_id    = '0;
    cdb_val   = '0;
    robid_out = '0;
    flags_out = '0;
    wbs_out   = '0;
    value_out = '0;
    if (cdb_grant) begin
      if (cdb_empty) begin
        cdb_id  = wbs[TAGW-1:0];
        cdb_val = result;
      end else begin
        cdb_id  = cdb_tag_q[cdb_head];
        cdb_val = cdb_res_q[cdb_head];
      end
    end
    if (rob_grant) begin
      if (rob_empty) begin
        robid_out = robid;
        flags_out = flags;
        wbs_out   = wbs;
        value_out = result;
      end else begin
        robid_out = rob_id_q[rob_head];
        flags_out = rob_flg_q[rob_head];
        wbs_out   = rob_wbs_q[rob_head];
        value_out = rob_res_q[rob_head];
      end
    end
  end

  // Entry storage carries no reset; a cleared count makes stale data unreachable.
  always_ff @(posedge clk) begin
    if (cdb_push) begin
      cdb_res_q[cdb_tail] <= result;
      cdb_tag_q[cdb_tail] <= wbs[TAGW-1:0];
    end
    if (rob_push) begin
      rob_res_q[rob_tail] <= result;
      rob_wbs_q[rob_tail] <= wbs;
      rob_flg_q[rob_tail] <= flags;
      rob_id_q[rob_tail]  <= robid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_cnt  <= '0;
      cdb_head <= '0;
      cdb_tail <= '0;
      rob_cnt  <= '0;
      rob_head <= '0;
      rob_tail <= '0;
      overflow <= 1'b0;
    end else begin
      if (input_transmit & busy) overflow <= 1'b1;
      if (cdb_push) cdb_tail <= ptr_inc(cdb_tail);
      if (cdb_pop)  cdb_head <= ptr_inc(cdb_head);
      if (cdb_push & ~cdb_pop)      cdb_cnt <= cdb_cnt + 1'b1;
      else if (~cdb_push & cdb_pop) cdb_cnt <= cdb_cnt - 1'b1;
      if (rob_push) rob_tail <= ptr_inc(rob_tail);
      if (rob_pop)  rob_head <= ptr_inc(rob_head);
      if (rob_push & ~rob_pop)      rob_cnt <= rob_cnt + 1'b1;
      else if (~rob_push & rob_pop) rob_cnt <= rob_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_alufu_q.sv
// Directed bench for alufu_q: bypass, split drain, fill/overflow, push+pop wrap,
// shifts/compares and asynchronous reset mid-drain.
module tb_alufu_q;

  logic            clk = 1'b0;
  logic            rst;
  logic            input_transmit;
  logic [7:0]      operand;
  logic [1:0][7:0] depvals;
  logic [7:0]      wbs;
  logic [7:0]      flags;
  logic [3:0]      robid;
  logic            cdb_transmit;
  logic            cdb_transmit_out;
  logic [3:0]      cdb_id;
  logic [7:0]      cdb_val;
  logic            rob_transmit;
  logic            rob_transmit_out;
  logic [3:0]      robid_out;
  logic [7:0]      flags_out;
  logic [7:0]      wbs_out;
  logic [7:0]      value_out;
  logic            busy;
  logic            overflow;

  int compared   = 0;
  int mismatched = 0;

  alufu_q #(.W(8), .TAGW(4), .WBSW(8), .FLAGW(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .input_transmit(input_transmit), .operand(operand),
    .depvals(depvals), .wbs(wbs), .flags(flags), .robid(robid),
    .cdb_transmit(cdb_transmit), .cdb_transmit_out(cdb_transmit_out),
    .cdb_id(cdb_id), .cdb_val(cdb_val),
    .rob_transmit(rob_transmit), .rob_transmit_out(rob_transmit_out),
    .robid_out(robid_out), .flags_out(flags_out), .wbs_out(wbs_out),
    .value_out(value_out), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic iss(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] w, input logic [3:0] id);
    input_transmit = 1'b1;
    operand        = {op, 4'h0};
    depvals[1]     = a;
    depvals[0]     = b;
    wbs            = w;
    flags          = 8'hA5;
    robid          = id;
  endtask

  task automatic idle();
    input_transmit = 1'b0;
    operand        = 8'h00;
    depvals        = '0;
    wbs            = 8'h00;
    robid          = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    cdb_transmit = 1'b0;
    rob_transmit = 1'b0;
    flags = 8'h00;
    idle();
    #2;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cdb_val", 32'(cdb_val), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    cdb_transmit = 1'b1;
    #1;
    chk("rst_cdb_pass", 32'(cdb_transmit_out), 32'h1);
    cdb_transmit = 1'b0;
    #1;
    chk("rst_cdb_pass0", 32'(cdb_transmit_out), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // bypass
    @(negedge clk);
    iss(4'h0, 8'h7F, 8'h01, 8'h25, 4'h3);
    #1;
    chk("byp_cdb_id", 32'(cdb_id), 32'h5);
    chk("byp_cdb_val", 32'(cdb_val), 32'h80);
    chk("byp_robid", 32'(robid_out), 32'h3);
    chk("byp_value", 32'(value_out), 32'h80);
    chk("byp_wbs", 32'(wbs_out), 32'h25);
    chk("byp_flags", 32'(flags_out), 32'hA5);
    chk("byp_cdb_tx", 32'(cdb_transmit_out), 32'h1);
    @(negedge clk);
    idle();
    #1;
    chk("byp_busy", 32'(busy), 32'h0);
    chk("byp_cdb_empty", 32'(cdb_transmit_out), 32'h0);
    chk("byp_rob_empty", 32'(rob_transmit_out), 32'h0);

    // split drain
    @(negedge clk);
    cdb_transmit = 1'b1;
    iss(4'h1, 8'h05, 8'h07, 8'h1A, 4'h6);
    #1;
    chk("split_rob_val", 32'(value_out), 32'hFE);
    chk("split_rob_id", 32'(robid_out), 32'h6);
    chk("split_cdb_held", 32'(cdb_val), 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("split_cdb_wait", 32'(cdb_val), 32'h0);
    chk("split_rob_idle", 32'(rob_transmit_out), 32'h0);
    @(negedge clk);
    cdb_transmit = 1'b0;
    #1;
    chk("split_cdb_val", 32'(cdb_val), 32'hFE);
    chk("split_cdb_id", 32'(cdb_id), 32'hA);
    chk("split_cdb_tx", 32'(cdb_transmit_out), 32'h1);
    @(negedge clk);
    #1;
    chk("split_cdb_done", 32'(cdb_transmit_out), 32'h0);

    // fill and overflow
    cdb_transmit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iss(4'h0, 8'(i), 8'h10, 8'(i + 1), 4'(i));
      #1;
      chk("fill_rob_val", 32'(value_out), 32'(8'h10 + 8'(i)));
      chk("fill_busy_pre", 32'(busy), 32'h0);
    end
    @(negedge clk);
    iss(4'h0, 8'h55, 8'h00, 8'h0F, 4'hF);
    #1;
    chk("ovf_busy", 32'(busy), 32'h1);
    chk("ovf_rob_drop", 32'(value_out), 32'h0);
    chk("ovf_rob_tx", 32'(rob_transmit_out), 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("ovf_flag", 32'(overflow), 32'h1);
    cdb_transmit = 1'b0;
    #1;
    chk("drain_busy_hold", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      chk("drain_val", 32'(cdb_val), 32'(8'h10 + 8'(i)));
      chk("drain_id", 32'(cdb_id), 32'(i + 1));
    end
    @(negedge clk);
    #1;
    chk("drain_empty", 32'(cdb_transmit_out), 32'h0);
    chk("drain_busy", 32'(busy), 32'h0);
    chk("drain_ovf_sticky", 32'(overflow), 32'h1);

    // push and pop together across pointer wrap
    cdb_transmit = 1'b1;
    @(negedge clk);
    iss(4'h2, 8'hF0, 8'h3C, 8'h07, 4'h1);
    @(negedge clk);
    iss(4'h3, 8'hF0, 8'h0F, 8'h08, 4'h2);
    @(negedge clk);
    cdb_transmit = 1'b0;
    iss(4'h4, 8'hAA, 8'hFF, 8'h09, 4'h3);
    #1;
    chk("pp_head0", 32'(cdb_val), 32'h30);
    chk("pp_id0", 32'(cdb_id), 32'h7);
    chk("pp_rob_byp", 32'(value_out), 32'h55);
    @(negedge clk);
    iss(4'h5, 8'h0F, 8'h30, 8'h0A, 4'h4);
    #1;
    chk("pp_head1", 32'(cdb_val), 32'hFF);
    chk("pp_busy", 32'(busy), 32'h0);
    @(negedge clk);
    iss(4'h6, 8'hFF, 8'h0F, 8'h0B, 4'h5);
    #1;
    chk("pp_head2", 32'(cdb_val), 32'h55);
    @(negedge clk);
    iss(4'h7, 8'hC3, 8'h0F, 8'h0C, 4'h6);
    #1;
    chk("pp_head3", 32'(cdb_val), 32'hC0);
    chk("pp_id3", 32'(cdb_id), 32'hA);
    @(negedge clk);
    idle();
    #1;
    chk("pp_head4", 32'(cdb_val), 32'hF0);
    chk("pp_id4", 32'(cdb_id), 32'hB);
    @(negedge clk);
    #1;
    chk("pp_head5", 32'(cdb_val), 32'h33);
    chk("pp_id5", 32'(cdb_id), 32'hC);
    @(negedge clk);
    #1;
    chk("pp_empty", 32'(cdb_transmit_out), 32'h0);

    // shifts, compares, pass-through
    @(negedge clk);
    iss(4'hA, 8'h80, 8'h09, 8'h01, 4'h1);
    #1;
    chk("sar_big", 32'(cdb_val), 32'hFF);
    @(negedge clk);
    iss(4'h8, 8'h01, 8'h07, 8'h01, 4'h1);
    #1;
    chk("shl_7", 32'(value_out), 32'h80);
    @(negedge clk);
    iss(4'hB, 8'hFF, 8'h01, 8'h01, 4'h1);
    #1;
    chk("slt", 32'(cdb_val), 32'h1);
    @(negedge clk);
    iss(4'hC, 8'hFF, 8'h01, 8'h01, 4'h1);
    #1;
    chk("sltu", 32'(cdb_val), 32'h0);
    @(negedge clk);
    iss(4'h9, 8'h80, 8'h08, 8'h01, 4'h1);
    #1;
    chk("shr_w", 32'(cdb_val), 32'h0);
    @(negedge clk);
    iss(4'h9, 8'h80, 8'h03, 8'h01, 4'h1);
    #1;
    chk("shr_3", 32'(cdb_val), 32'h10);
    @(negedge clk);
    iss(4'hA, 8'h90, 8'h02, 8'h01, 4'h1);
    #1;
    chk("sar_2", 32'(cdb_val), 32'hE4);
    @(negedge clk);
    iss(4'hD, 8'h3C, 8'h5A, 8'h01, 4'h1);
    #1;
    chk("pass_a", 32'(cdb_val), 32'h3C);
    @(negedge clk);
    iss(4'hE, 8'h3C, 8'h5A, 8'h01, 4'h1);
    #1;
    chk("pass_b", 32'(cdb_val), 32'h5A);
    @(negedge clk);
    iss(4'hF, 8'h3C, 8'h5A, 8'h01, 4'h1);
    #1;
    chk("op_f", 32'(cdb_val), 32'h0);

    // reset mid-drain
    cdb_transmit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iss(4'h0, 8'(i), 8'h20, 8'(i + 1), 4'(i));
    end
    @(negedge clk);
    idle();
    #2;
    rst = 1'b0;
    #1;
    chk("rstm_busy", 32'(busy), 32'h0);
    chk("rstm_ovf", 32'(overflow), 32'h0);
    chk("rstm_cdb_pass", 32'(cdb_transmit_out), 32'h1);
    cdb_transmit = 1'b0;
    #1;
    chk("rstm_cdb_tx", 32'(cdb_transmit_out), 32'h0);
    chk("rstm_cdb_val", 32'(cdb_val), 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rstm_no_stale_tx", 32'(cdb_transmit_out), 32'h0);
      chk("rstm_no_stale_val", 32'(cdb_val), 32'h0);
      chk("rstm_no_stale_id", 32'(cdb_id), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
